// File: rtl/fpu_ctrl_pkg.sv
// FP issue controller shared types: op encodings, register-index width and the div/sqrt decode.
package fpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FOP_ADD  = 3'b000,
        FOP_SUB  = 3'b001,
        FOP_MUL  = 3'b010,
        FOP_DIV  = 3'b100,
        FOP_SQRT = 3'b110
    } fop_t;

    typedef enum logic {
        DS_IDLE = 1'b0,
        DS_BUSY = 1'b1
    } ds_state_e;

    function automatic int ridx_f(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    // 01x is fmul, so every code at or above fdiv goes to the iterative unit
    function automatic logic is_ds(input logic [2:0] fop);
        return fop >= 3'(FOP_DIV);
    endfunction

endpackage

// File: rtl/fp_inflight_pipe.sv
// Valid/destination shift register mirroring the N pipelined FP stages, plus per-stage match vectors.
// Shifts every cycle with no hold; a match requires the stage to be valid.
module fp_inflight_pipe #(
    parameter int N    = 3,
    parameter int RIDX = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ld_vld_i,
    input  logic [RIDX-1:0] ld_rd_i,
    input  logic [RIDX-1:0] src_a_i,
    input  logic [RIDX-1:0] src_b_i,
    input  logic [RIDX-1:0] dst_i,
    output logic [N:1]      v_o,
    output logic [N:1]      match_a_o,
    output logic [N:1]      match_b_o,
    output logic [N:1]      match_d_o,
    output logic [RIDX-1:0] rd_last_o
);

    logic [N:1]      v_q;
    logic [RIDX-1:0] rd_q [1:N];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q <= '0;
            for (int k = 1; k <= N; k++) rd_q[k] <= '0;
        end else begin
            v_q     <= {v_q[N-1:1], ld_vld_i};
            rd_q[1] <= ld_rd_i;
            for (int k = 2; k <= N; k++) rd_q[k] <= rd_q[k-1];
        end
    end

    always_comb begin
        match_a_o = '0;
        match_b_o = '0;
        match_d_o = '0;
        for (int k = 1; k <= N; k++) begin
            match_a_o[k] = v_q[k] && (rd_q[k] == src_a_i);
            match_b_o[k] = v_q[k] && (rd_q[k] == src_b_i);
            match_d_o[k] = v_q[k] && (rd_q[k] == dst_i);
        end
    end

    assign v_o       = v_q;
    assign rd_last_o = rd_q[N];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue/hazard control: stall, forwarding selects, div/sqrt FSM and the single regfile write port.
// Optional FPU_STALL_CNT_EN adds saturating stall-cause counters; issue is combinational, stall holds ID.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter  int NREG   = 32,
    parameter  int FP_LAT = 3,
    parameter  int DS_LAT = 8,
    localparam int RIDX   = ridx_f(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [2:0]      id_fop_i,
    input  logic [RIDX-1:0] id_fd_i,
    input  logic [RIDX-1:0] id_fs_i,
    input  logic            id_use_fs_i,
    input  logic [RIDX-1:0] id_ft_i,
    input  logic            id_use_ft_i,
    input  logic            id_swc1_i,
    input  logic            ext_stall_i,
    output logic            issue_o,
    output logic            stall_o,
    output logic            fwd_a_o,
    output logic            fwd_b_o,
    output logic            fwd_st_o,
    output logic            ds_busy_o,
    output logic            wb_we_o,
    output logic [RIDX-1:0] wb_rd_o,
    output logic            wb_ds_o
`ifdef FPU_STALL_CNT_EN
    ,
    output logic [31:0]     cnt_raw_o,
    output logic [31:0]     cnt_struct_o,
    output logic [31:0]     cnt_ext_o
`endif
);

    localparam int CW = $clog2(DS_LAT + 1);

    logic [FP_LAT:1] pipe_v, m_a, m_b, m_d;
    logic [RIDX-1:0] pipe_rd;
    ds_state_e       ds_st_q, ds_st_d;
    logic [CW-1:0]   ds_cnt_q, ds_cnt_d;
    logic [RIDX-1:0] ds_rd_q, ds_rd_d;
    logic id_ds, ds_busy, ds_last, ds_wb, port_clash, ds_pipe_clash, st_early;
    logic fp_raw, fp_struct, haz_raw, haz_struct, stall, issue;

    fp_inflight_pipe #(.N(FP_LAT), .RIDX(RIDX)) u_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ld_vld_i  (issue & ~id_ds),
        .ld_rd_i   (id_fd_i),
        .src_a_i   (id_fs_i),
        .src_b_i   (id_ft_i),
        .dst_i     (id_fd_i),
        .v_o       (pipe_v),
        .match_a_o (m_a),
        .match_b_o (m_b),
        .match_d_o (m_d),
        .rd_last_o (pipe_rd)
    );

    always_comb begin
        id_ds         = is_ds(id_fop_i);
        ds_busy       = (ds_cnt_q != '0);
        ds_last       = (ds_cnt_q == CW'(1));
        // a pipelined op issued now retires FP_LAT cycles later, same as div/sqrt at this count
        port_clash    = (int'(ds_cnt_q) == FP_LAT + 1);
        ds_pipe_clash = 1'b0;
        st_early      = 1'b0;
        for (int k = 1; k <= FP_LAT; k++) begin
            if (FP_LAT - k == DS_LAT) ds_pipe_clash = ds_pipe_clash | pipe_v[k];
            if (k < FP_LAT - 1)       st_early      = st_early | m_b[k];
        end
        fp_raw     = (id_use_fs_i & (|m_a[FP_LAT-1:1]))
                   | (id_use_ft_i & (|m_b[FP_LAT-1:1]))
                   | (|m_d)
                   | (ds_busy & ((id_use_fs_i & (id_fs_i == ds_rd_q))
                               | (id_use_ft_i & (id_ft_i == ds_rd_q))
                               | (id_fd_i == ds_rd_q)));
        fp_struct  = id_ds ? ((ds_busy & ~ds_last) | ds_pipe_clash) : port_clash;
        haz_raw    = (id_valid_i & fp_raw)
                   | (id_swc1_i & (st_early | (ds_busy & (id_ft_i == ds_rd_q))));
        haz_struct = id_valid_i & fp_struct;
        stall      = ext_stall_i | haz_raw | haz_struct;
        issue      = id_valid_i & ~stall & ~rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ds_st_q  <= DS_IDLE;
            ds_cnt_q <= '0;
            ds_rd_q  <= '0;
        end else begin
            ds_st_q  <= ds_st_d;
            ds_cnt_q <= ds_cnt_d;
            ds_rd_q  <= ds_rd_d;
        end
    end

    always_comb begin
        ds_st_d  = ds_st_q;
        ds_cnt_d = ds_cnt_q;
        ds_rd_d  = ds_rd_q;
        ds_wb    = 1'b0;
        case (ds_st_q)
            DS_IDLE: begin
                if (issue && id_ds) begin
                    ds_st_d  = DS_BUSY;
                    ds_cnt_d = CW'(DS_LAT);
                    ds_rd_d  = id_fd_i;
                end
            end
            DS_BUSY: begin
                ds_cnt_d = ds_cnt_q - CW'(1);
                if (ds_last) begin
                    ds_wb   = 1'b1;
                    ds_st_d = DS_IDLE;
                    // back-to-back div/sqrt: the unit is free again next cycle
                    if (issue && id_ds) begin
                        ds_st_d  = DS_BUSY;
                        ds_cnt_d = CW'(DS_LAT);
                        ds_rd_d  = id_fd_i;
                    end
                end
            end
            default: ds_st_d = DS_IDLE;
        endcase
    end

    assign issue_o   = issue;
    assign stall_o   = stall;
    assign fwd_a_o   = id_valid_i & id_use_fs_i & m_a[FP_LAT];
    assign fwd_b_o   = ((id_valid_i & id_use_ft_i) | id_swc1_i) & m_b[FP_LAT];
    assign fwd_st_o  = id_swc1_i & m_b[FP_LAT-1];
    assign ds_busy_o = ds_busy;
    assign wb_we_o   = pipe_v[FP_LAT] | ds_wb;
    assign wb_rd_o   = ds_wb ? ds_rd_q : pipe_rd;
    assign wb_ds_o   = ds_wb;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!(ds_wb && pipe_v[FP_LAT]));
    end
`endif

`ifdef FPU_STALL_CNT_EN
    logic [31:0] cnt_raw_q, cnt_raw_d, cnt_struct_q, cnt_struct_d, cnt_ext_q, cnt_ext_d;

    always_comb begin
        cnt_raw_d    = cnt_raw_q;
        cnt_struct_d = cnt_struct_q;
        cnt_ext_d    = cnt_ext_q;
        if (ext_stall_i) begin
            if (~&cnt_ext_q) cnt_ext_d = cnt_ext_q + 32'd1;
        end else if (haz_struct) begin
            if (~&cnt_struct_q) cnt_struct_d = cnt_struct_q + 32'd1;
        end else if (haz_raw) begin
            if (~&cnt_raw_q) cnt_raw_d = cnt_raw_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_raw_q    <= '0;
            cnt_struct_q <= '0;
            cnt_ext_q    <= '0;
        end else begin
            cnt_raw_q    <= cnt_raw_d;
            cnt_struct_q <= cnt_struct_d;
            cnt_ext_q    <= cnt_ext_d;
        end
    end

    assign cnt_raw_o    = cnt_raw_q;
    assign cnt_struct_o = cnt_struct_q;
    assign cnt_ext_o    = cnt_ext_q;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl (FP_LAT=3, DS_LAT=8) with hand-computed expectations.
module tb_fpu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_fs, id_use_ft, id_swc1, ext_stall;
    logic [2:0] id_fop;
    logic [4:0] id_fd, id_fs, id_ft;
    logic       issue, stall, fwd_a, fwd_b, fwd_st, ds_busy, wb_we, wb_ds;
    logic [4:0] wb_rd;
`ifdef FPU_STALL_CNT_EN
    logic [31:0] cnt_raw, cnt_struct, cnt_ext;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_st;
    int n_wb;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.NREG(32), .FP_LAT(3), .DS_LAT(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .id_valid_i  (id_valid),
        .id_fop_i    (id_fop),
        .id_fd_i     (id_fd),
        .id_fs_i     (id_fs),
        .id_use_fs_i (id_use_fs),
        .id_ft_i     (id_ft),
        .id_use_ft_i (id_use_ft),
        .id_swc1_i   (id_swc1),
        .ext_stall_i (ext_stall),
        .issue_o     (issue),
        .stall_o     (stall),
        .fwd_a_o     (fwd_a),
        .fwd_b_o     (fwd_b),
        .fwd_st_o    (fwd_st),
        .ds_busy_o   (ds_busy),
        .wb_we_o     (wb_we),
        .wb_rd_o     (wb_rd),
        .wb_ds_o     (wb_ds)
`ifdef FPU_STALL_CNT_EN
        ,
        .cnt_raw_o    (cnt_raw),
        .cnt_struct_o (cnt_struct),
        .cnt_ext_o    (cnt_ext)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_valid  = 1'b0;
        id_fop    = 3'b000;
        id_fd     = '0;
        id_fs     = '0;
        id_ft     = '0;
        id_use_fs = 1'b0;
        id_use_ft = 1'b0;
        id_swc1   = 1'b0;
        ext_stall = 1'b0;
    endtask

    task automatic set_op(input logic [2:0] fop, input logic [4:0] fd, input logic [4:0] fs,
                          input logic [4:0] ft, input logic ufs, input logic uft);
        id_valid  = 1'b1;
        id_fop    = fop;
        id_fd     = fd;
        id_fs     = fs;
        id_ft     = ft;
        id_use_fs = ufs;
        id_use_ft = uft;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        // reset: nothing issues even with a valid op
        set_op(3'b000, 5'd13, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        chk("rst_issue", issue, 0);
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_ds_busy", ds_busy, 0);

        // RAW on pipelined result: two stalls then forward from e3
        tick();
        set_op(3'b000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        chk("s1_issue_add", issue, 1);
        tick();
        set_op(3'b010, 5'd2, 5'd1, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        chk("s1_stall1", stall, 1);
        chk("s1_hold", issue, 0);
        tick();
        @(negedge clk);
        chk("s1_stall2", stall, 1);
        tick();
        @(negedge clk);
        chk("s1_issue_mul", issue, 1);
        chk("s1_fwd_a", fwd_a, 1);
        chk("s1_fwd_b", fwd_b, 0);
        chk("s1_wb_we", wb_we, 1);
        chk("s1_wb_rd", wb_rd, 1);
        tick();
        idle();
        @(negedge clk);
        chk("s1_wb_gap", wb_we, 0);
        tick();
        tick();
        @(negedge clk);
        chk("s1_wb2_we", wb_we, 1);
        chk("s1_wb2_rd", wb_rd, 2);

        // fdiv f4 then dependent fadd: 8 stall cycles, div writeback on the 8th
        tick();
        set_op(3'b100, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        chk("s2_issue_div", issue, 1);
        tick();
        set_op(3'b000, 5'd5, 5'd4, 5'd6, 1'b1, 1'b1);
        n_st = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (stall) n_st++;
            if (i == 7) begin
                chk("s2_ds_we", wb_we, 1);
                chk("s2_ds_sel", wb_ds, 1);
                chk("s2_ds_rd", wb_rd, 4);
            end
            tick();
        end
        @(negedge clk);
        chk("s2_stall_cycles", n_st, 8);
        chk("s2_issue_add", issue, 1);
        chk("s2_ds_idle", ds_busy, 0);
        tick();
        idle();
        tick();
        tick();
        @(negedge clk);
        chk("s2_add_rd", wb_rd, 5);
        chk("s2_add_sel", wb_ds, 0);

        // fsqrt f7; second div/sqrt refused while busy; port conflict at ds_cnt==4
        tick();
        set_op(3'b110, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("s3_issue_sqrt", issue, 1);
        tick();
        set_op(3'b100, 5'd20, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        chk("s3_ds_struct", stall, 1);
        tick();
        idle();
        tick();
        tick();
        tick();
        set_op(3'b000, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        chk("s3_port_stall", stall, 1);
        tick();
        @(negedge clk);
        chk("s3_port_issue", issue, 1);
        tick();
        idle();
        @(negedge clk);
        chk("s3_wb_quiet", wb_we, 0);
        tick();
        set_op(3'b100, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        chk("s3_sqrt_sel", wb_ds, 1);
        chk("s3_sqrt_rd", wb_rd, 7);
        chk("s3_div_at_last", issue, 1);
        tick();
        set_op(3'b000, 5'd11, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        chk("s3_add_we", wb_we, 1);
        chk("s3_add_rd", wb_rd, 8);
        chk("s3_add_sel", wb_ds, 0);
        chk("s3_div_busy", ds_busy, 1);
        tick();
        set_op(3'b010, 5'd12, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        chk("s3_issue_mul", issue, 1);

        // reset with two ops in the pipe and div busy: nothing retires afterwards
        tick();
        rst = 1'b1;
        set_op(3'b000, 5'd13, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        chk("s5_rst_issue", issue, 0);
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("s5_ds_busy", ds_busy, 0);
        n_wb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wb_we) n_wb++;
            tick();
        end
        chk("s5_no_wb", n_wb, 0);

        // swc1 after fmul f9: one stall, then fwd_st, then fwd_b
        set_op(3'b010, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        chk("s4_issue_mul", issue, 1);
        tick();
        idle();
        id_swc1 = 1'b1;
        id_ft   = 5'd9;
        @(negedge clk);
        chk("s4_stall", stall, 1);
        chk("s4_no_fwd_st", fwd_st, 0);
        tick();
        @(negedge clk);
        chk("s4_fwd_st", fwd_st, 1);
        chk("s4_go", stall, 0);
        chk("s4_st_not_b", fwd_b, 0);
        tick();
        @(negedge clk);
        chk("s4_fwd_b", fwd_b, 1);
        chk("s4_b_not_st", fwd_st, 0);

        // ext_stall for 3 cycles: no issue, fadd f15 still retires on the 3rd
        tick();
        idle();
        set_op(3'b000, 5'd15, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        chk("s6_issue", issue, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_op(3'b000, 5'd16, 5'd1, 5'd2, 1'b1, 1'b1);
            ext_stall = 1'b1;
            @(negedge clk);
            chk("s6_ext_hold", issue, 0);
        end
        chk("s6_wb_we", wb_we, 1);
        chk("s6_wb_rd", wb_rd, 15);
        tick();
        ext_stall = 1'b0;
        @(negedge clk);
        chk("s6_resume", issue, 1);
        tick();
        set_op(3'b010, 5'd16, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        chk("s6_waw", stall, 1);
        tick();
        idle();
        @(negedge clk);
        chk("s6_novalid", stall, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
